// File: rtl/alu_pkg.sv
//------------------------------------------------------------------------------
// Module   : alu_pkg
// Brief    : Opcodes, flag bit positions and sequencer states shared by the
//            ALU, its sequencer and the decode logic.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package alu_pkg;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_SHL = 3'd2,
        ALU_SHR = 3'd3,
        ALU_SAR = 3'd4,
        ALU_AND = 3'd5,
        ALU_OR  = 3'd6,
        ALU_XOR = 3'd7
    } alu_op_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_RESP    = 2'd3
    } seq_state_e;

endpackage

`default_nettype wire

// File: rtl/alu_flag_gen.sv
//------------------------------------------------------------------------------
// Module   : alu_flag_gen
// Brief    : Combinational N/Z/C/V generation from opcode, operands and result.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module alu_flag_gen
    import alu_pkg::*;
(
    input  logic [2:0]  op_i,
    input  logic [15:0] operand1_i,
    input  logic [15:0] operand2_i,
    input  logic [15:0] result_i,
    output logic [3:0]  flags_o
);

    always_comb begin
        flags_o         = 4'b0000;
        flags_o[FLAG_N] = result_i[15];
        flags_o[FLAG_Z] = (result_i == 16'h0000);
        case (alu_op_e'(op_i))
            ALU_ADD: begin
                // a + b overflows 16 bits exactly when a exceeds 0xFFFF - b.
                flags_o[FLAG_C] = (operand1_i > ~operand2_i);
                flags_o[FLAG_V] = (operand1_i[15] == operand2_i[15]) &&
                                  (result_i[15] != operand1_i[15]);
            end
            ALU_SUB: begin
                flags_o[FLAG_C] = (operand1_i < operand2_i);
                flags_o[FLAG_V] = (operand1_i[15] != operand2_i[15]) &&
                                  (result_i[15] != operand1_i[15]);
            end
            default: begin
                flags_o[FLAG_C] = 1'b0;
                flags_o[FLAG_V] = 1'b0;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/alu_sequencer.sv
//------------------------------------------------------------------------------
// Module   : alu_sequencer
// Brief    : Valid/ready request front-end for the registered 16-bit ALU;
//            captures the result one cycle later and returns it with flags.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module alu_sequencer
    import alu_pkg::*;
#(
    parameter int TAG_W = 4
)
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [2:0]       req_operation_i,
    input  logic [15:0]      req_operand1_i,
    input  logic [15:0]      req_operand2_i,
    input  logic [TAG_W-1:0] req_tag_i,
    output logic [2:0]       alu_operation_o,
    output logic [15:0]      alu_operand1_o,
    output logic [15:0]      alu_operand2_o,
    input  logic [15:0]      alu_result_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [15:0]      rsp_result_o,
    output logic [3:0]       rsp_flags_o,
    output logic [TAG_W-1:0] rsp_tag_o
);

    seq_state_e       state_q, state_d;
    logic [2:0]       op_q;
    logic [15:0]      opa_q;
    logic [15:0]      opb_q;
    logic [TAG_W-1:0] tag_q;
    logic [15:0]      res_q;
    logic [3:0]       flags_q;
    logic [TAG_W-1:0] rsp_tag_q;
    logic [3:0]       w_flags;
    logic             w_accept;

    assign w_accept = req_valid_i && req_ready_o;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        req_ready_o = 1'b0;
        rsp_valid_o = 1'b0;
        case (state_q)
            ST_IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                state_d = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid_o = 1'b1;
                // Completing a response frees the slot for a new request in the same cycle.
                if (rsp_ready_i) begin
                    req_ready_o = 1'b1;
                    state_d     = req_valid_i ? ST_ISSUE : ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            op_q  <= 3'd0;
            opa_q <= 16'h0000;
            opb_q <= 16'h0000;
            tag_q <= '0;
        end else if (w_accept) begin
            op_q  <= req_operation_i;
            opa_q <= req_operand1_i;
            opb_q <= req_operand2_i;
            tag_q <= req_tag_i;
        end
    end

    alu_flag_gen u_flag_gen (
        .op_i       (op_q),
        .operand1_i (opa_q),
        .operand2_i (opb_q),
        .result_i   (alu_result_i),
        .flags_o    (w_flags)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            res_q     <= 16'h0000;
            flags_q   <= 4'b0000;
            rsp_tag_q <= '0;
        end else if (state_q == ST_CAPTURE) begin
            res_q     <= alu_result_i;
            flags_q   <= w_flags;
            rsp_tag_q <= tag_q;
        end
    end

    assign alu_operation_o = op_q;
    assign alu_operand1_o  = opa_q;
    assign alu_operand2_o  = opb_q;
    assign rsp_result_o    = res_q;
    assign rsp_flags_o     = flags_q;
    assign rsp_tag_o       = rsp_tag_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_sequencer.sv
//------------------------------------------------------------------------------
// Module   : tb_alu_sequencer
// Brief    : Scoreboard bench for alu_sequencer with a behavioural registered ALU.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_alu_sequencer;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic [3:0]  req_tag;
    logic [2:0]  alu_op;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [15:0] alu_res;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_result;
    logic [3:0]  rsp_flags;
    logic [3:0]  rsp_tag;

    typedef struct {
        logic [15:0] res;
        logic [3:0]  flg;
        logic [3:0]  tag;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    bit   head_seen = 1'b0;
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    alu_sequencer #(.TAG_W(4)) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .req_valid_i     (req_valid),
        .req_ready_o     (req_ready),
        .req_operation_i (req_op),
        .req_operand1_i  (req_a),
        .req_operand2_i  (req_b),
        .req_tag_i       (req_tag),
        .alu_operation_o (alu_op),
        .alu_operand1_o  (alu_a),
        .alu_operand2_o  (alu_b),
        .alu_result_i    (alu_res),
        .rsp_valid_o     (rsp_valid),
        .rsp_ready_i     (rsp_ready),
        .rsp_result_o    (rsp_result),
        .rsp_flags_o     (rsp_flags),
        .rsp_tag_o       (rsp_tag)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Registered ALU model standing in for the real datapath.
    always @(posedge clk) begin
        case (alu_op)
            3'd0:    alu_res <= alu_a + alu_b;
            3'd1:    alu_res <= alu_a - alu_b;
            3'd2:    alu_res <= alu_a << alu_b;
            3'd3:    alu_res <= alu_a >> alu_b;
            3'd4:    alu_res <= $unsigned($signed(alu_a) >>> alu_b);
            3'd5:    alu_res <= alu_a & alu_b;
            3'd6:    alu_res <= alu_a | alu_b;
            default: alu_res <= alu_a ^ alu_b;
        endcase
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    task automatic send(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic [3:0] tg, input logic [15:0] er, input logic [3:0] ef,
                        input bit track);
        exp_t e;
        bit   done;
        done = 1'b0;
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_tag   = tg;
        for (int n = 0; n < 40 && !done; n++) begin
            #1;
            if (req_ready) begin
                if (track) begin
                    e.res = er;
                    e.flg = ef;
                    e.tag = tg;
                    e.cyc = cyc + 3;
                    sb.push_back(e);
                end
                done = 1'b1;
                @(posedge clk);
                #1 req_valid = 1'b0;
            end else begin
                @(negedge clk);
            end
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: tag %0h never accepted", tg);
            req_valid = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        #2;
        if (!rst && rsp_valid) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL spurious_rsp: got result %0h tag %0h expected none", rsp_result, rsp_tag);
            end else begin
                if (!head_seen) begin
                    chk("latency", cyc, sb[0].cyc);
                    head_seen = 1'b1;
                end
                chk("result", {16'h0, rsp_result}, {16'h0, sb[0].res});
                chk("flags", {28'h0, rsp_flags}, {28'h0, sb[0].flg});
                chk("tag", {28'h0, rsp_tag}, {28'h0, sb[0].tag});
                if (rsp_ready) begin
                    void'(sb.pop_front());
                    head_seen = 1'b0;
                end else begin
                    chk("req_ready_bp", {31'h0, req_ready}, 32'h0);
                end
            end
        end
    end

    initial begin
        rst       = 1'b0;
        req_valid = 1'b0;
        req_op    = 3'd0;
        req_a     = 16'h0;
        req_b     = 16'h0;
        req_tag   = 4'h0;
        rsp_ready = 1'b1;
        #1 rst = 1'b1;
        #2;
        chk("rst_req_ready", {31'h0, req_ready}, 32'h1);
        chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        chk("rst_rsp_out", {8'h0, rsp_result, rsp_flags, rsp_tag}, 32'h0);
        chk("rst_alu_out", {alu_op, alu_a, alu_b[12:0]}, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        send(3'd0, 16'hFFFF, 16'h0001, 4'h5, 16'h0000, 4'b0110, 1'b1);
        send(3'd1, 16'h8000, 16'h0001, 4'h6, 16'h7FFF, 4'b0001, 1'b1);
        send(3'd1, 16'h0001, 16'h0002, 4'h7, 16'hFFFF, 4'b1010, 1'b1);
        send(3'd0, 16'h7FFF, 16'h0001, 4'h2, 16'h8000, 4'b1001, 1'b1);
        send(3'd4, 16'h8000, 16'h0001, 4'h3, 16'hC000, 4'b1000, 1'b1);
        send(3'd5, 16'hF0F0, 16'h0F0F, 4'h4, 16'h0000, 4'b0100, 1'b1);
        repeat (4) @(negedge clk);

        // In-flight operation killed by reset while in CAPTURE.
        send(3'd0, 16'h1234, 16'h1111, 4'hE, 16'h0000, 4'b0000, 1'b0);
        @(negedge clk);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("midrst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        chk("midrst_req_ready", {31'h0, req_ready}, 32'h1);
        chk("midrst_rsp_out", {8'h0, rsp_result, rsp_flags, rsp_tag}, 32'h0);
        chk("midrst_alu_a", {16'h0, alu_a}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        send(3'd0, 16'h0001, 16'h0001, 4'h1, 16'h0002, 4'b0000, 1'b1);
        repeat (4) @(negedge clk);

        // Backpressure with a pending request accepted on release.
        rsp_ready = 1'b0;
        send(3'd0, 16'h0003, 16'h0004, 4'h8, 16'h0007, 4'b0000, 1'b1);
        fork
            send(3'd7, 16'h00FF, 16'h0F0F, 4'h9, 16'h0FF0, 4'b0000, 1'b1);
            begin
                bit seen;
                seen = 1'b0;
                for (int i = 0; i < 10 && !seen; i++) begin
                    @(negedge clk);
                    #1 seen = rsp_valid;
                end
                if (!seen) begin
                    total++;
                    bad++;
                    $display("FAIL bp_rsp_timeout: rsp_valid 0 expected 1");
                end
                repeat (5) @(negedge clk);
                rsp_ready = 1'b1;
            end
        join

        send(3'd2, 16'h0001, 16'h0004, 4'hA, 16'h0010, 4'b0000, 1'b1);
        send(3'd6, 16'h1200, 16'h0034, 4'hB, 16'h1234, 4'b0000, 1'b1);

        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d responses outstanding expected 0", sb.size());
        end
        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
